// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge controller.
// Holds the FSM state encoding, AHB transfer/response codes and the
// default peripheral region map (three 64 MB regions).
package apb_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RSETUP,
      ST_RENABLE,
      ST_WWAIT,
      ST_WSETUP,
      ST_WENABLE
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY = 2'b00;

   localparam logic [31:0] SLV0_BASE_DFLT = 32'h8000_0000;
   localparam logic [31:0] SLV1_BASE_DFLT = 32'h8400_0000;
   localparam logic [31:0] SLV2_BASE_DFLT = 32'h8800_0000;
   localparam logic [31:0] REGION_SIZE    = 32'h0400_0000;

endpackage

// File: rtl/apb_addr_decode.sv
// AHB address decoder: maps an address onto one of three 64 MB peripheral regions.
// Purely combinational (zero latency); no flow control.
// Ports: addr (in, 32) -> in_range (out, 1), sel (out, 3, one-hot, 0 when out of range).
module apb_addr_decode
   import apb_bridge_pkg::*;
#(
   parameter logic [31:0] SLV0_BASE = SLV0_BASE_DFLT,
   parameter logic [31:0] SLV1_BASE = SLV1_BASE_DFLT,
   parameter logic [31:0] SLV2_BASE = SLV2_BASE_DFLT
) (
   input  logic [31:0] addr,
   output logic        in_range,
   output logic [2:0]  sel
);

   logic [31:0] off0, off1, off2;

   // Unsigned offset from each base; a wrap below the base becomes a huge
   // offset, so a single compare covers both region bounds.
   assign off0 = addr - SLV0_BASE;
   assign off1 = addr - SLV1_BASE;
   assign off2 = addr - SLV2_BASE;

   assign sel[0]   = (off0 < REGION_SIZE);
   assign sel[1]   = (off1 < REGION_SIZE);
   assign sel[2]   = (off2 < REGION_SIZE);
   assign in_range = |sel;

endmodule

// File: rtl/apb_bridge_controller.sv
// AHB-to-APB bridge sequencer: one APB access outstanding, AHB stalled via Hreadyout.
// Latency: read 1 AHB wait state, write 2 wait states; next address phase accepted in ENABLE.
// Ports: AHB side Hwrite/Hreadyin/Htrans/Haddr/Hwdata in, Hreadyout/Hresp/Hrdata out;
//        APB side Prdata in, Pselx/Penable/Pwrite/Paddr/Pwdata out (all registered).
module apb_bridge_controller
   import apb_bridge_pkg::*;
#(
   parameter logic [31:0] SLV0_BASE = SLV0_BASE_DFLT,
   parameter logic [31:0] SLV1_BASE = SLV1_BASE_DFLT,
   parameter logic [31:0] SLV2_BASE = SLV2_BASE_DFLT
) (
   input  logic        Hclk,
   input  logic        Hreset,
   input  logic        Hwrite,
   input  logic        Hreadyin,
   input  logic [1:0]  Htrans,
   input  logic [31:0] Haddr,
   input  logic [31:0] Hwdata,
   input  logic [31:0] Prdata,
   output logic        Hreadyout,
   output logic [1:0]  Hresp,
   output logic [31:0] Hrdata,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic        Pwrite,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata
);

   state_t      state;
   logic [2:0]  sel_q;      // select held across WWAIT, where Pselx must stay 0
   logic        in_range;
   logic [2:0]  dec_sel;
   logic        valid;

   apb_addr_decode #(
      .SLV0_BASE (SLV0_BASE),
      .SLV1_BASE (SLV1_BASE),
      .SLV2_BASE (SLV2_BASE)
   ) u_decode (
      .addr     (Haddr),
      .in_range (in_range),
      .sel      (dec_sel)
   );

   assign valid = Hreadyin & ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ)) & in_range;

   assign Hresp  = HRESP_OKAY;
   // Read data passes straight through during the enable phase only.
   assign Hrdata = (state == ST_RENABLE) ? Prdata : 32'h0;

   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state     <= ST_IDLE;
         sel_q     <= 3'b000;
         Pselx     <= 3'b000;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= 32'h0;
         Pwdata    <= 32'h0;
         Hreadyout <= 1'b1;
      end else begin
         case (state)
            // Hreadyout is high in these states, so the AHB bus is sampled here.
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
               Penable <= 1'b0;
               Pwrite  <= 1'b0;
               if (valid) begin
                  Paddr     <= Haddr;
                  sel_q     <= dec_sel;
                  Hreadyout <= 1'b0;
                  if (Hwrite) begin
                     state <= ST_WWAIT;
                     Pselx <= 3'b000;
                  end else begin
                     state <= ST_RSETUP;
                     Pselx <= dec_sel;
                  end
               end else begin
                  state     <= ST_IDLE;
                  Pselx     <= 3'b000;
                  Hreadyout <= 1'b1;
               end
            end
            ST_RSETUP: begin
               state     <= ST_RENABLE;
               Penable   <= 1'b1;
               Hreadyout <= 1'b1;
            end
            // Write data arrives one cycle after its address phase.
            ST_WWAIT: begin
               state  <= ST_WSETUP;
               Pwdata <= Hwdata;
               Pselx  <= sel_q;
               Pwrite <= 1'b1;
            end
            ST_WSETUP: begin
               state     <= ST_WENABLE;
               Penable   <= 1'b1;
               Hreadyout <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               Pselx     <= 3'b000;
               Penable   <= 1'b0;
               Pwrite    <= 1'b0;
               Hreadyout <= 1'b1;
            end
         endcase
      end
   end

endmodule
